edge_detect_mc: RTL
===================

Name: edge_detect_mc

Overview:
Multi-channel, parametrised edge detector for asynchronous level inputs such as buttons, external strobes and GPIO.
- Each channel has a synchroniser, a programmable glitch filter, rise/fall pulse outputs, a per-channel mode select, and sticky event flags with a combined interrupt.
- Sits between raw pins and the control/interrupt logic.
- Replaces single-bit ad-hoc edge detection in new designs.

Parameters:
CH, 8, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_W, 4, width of the glitch-filter length field and counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
din  input  CH  raw asynchronous inputs, one bit per channel
mode  input  2*CH  per-channel event select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
filt_len  input  FILT_W  glitch-filter length shared by all channels; 0 = no filtering
clr  input  CH  per-channel sticky-flag clear, 1-cycle pulse, synchronous to clk
level  output  CH  filtered, synchronised level
rise  output  CH  1-cycle pulse on filtered 0->1 transition (independent of mode)
fall  output  CH  1-cycle pulse on filtered 1->0 transition (independent of mode)
evt  output  CH  1-cycle pulse: rise/fall masked by mode
flag  output  CH  sticky event flag
irq  output  1  OR of all flag bits

Behaviour:
- Reset (rst_n low, asynchronous):
  - Synchroniser flops, level, filter counters, rise, fall, evt and flag all go to 0.
  - irq is 0.
- Synchroniser: din[i] passes through SYNC_STAGES flops. s[i] denotes the last stage.
- Filter, per channel, with counter cnt[i] of FILT_W bits:
  - When s[i]==level[i]: cnt[i] <= 0.
  - When s[i]!=level[i] and cnt[i] >= filt_len: level[i] <= s[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - Net effect: a change is accepted after filt_len+1 consecutive differing cycles.
  - Any bounce back to level[i] restarts the count.
  - filt_len changing mid-count takes effect immediately. The >= compare ensures no lock-up when cnt[i] exceeds the new value.
- Edge pulses are registered in the same cycle level[i] updates:
  - rise[i]=1 exactly when level goes 0->1; fall[i]=1 exactly when it goes 1->0. Each is high for exactly one cycle.
  - rise[i] and fall[i] are never both high.
  - Back-to-back accepted edges with filt_len=0 give alternating pulses in adjacent cycles.
- Latency: count the first clk edge that samples a new stable din value as edge 0. rise/fall/evt/level are visible after edge SYNC_STAGES+filt_len.
- evt[i] = (rise[i] & mode[2i]) | (fall[i] & mode[2i+1]), registered so it is aligned with rise/fall.
  - A mode change affects only edges accepted after the change.
  - mode 00 suppresses evt and flag. rise, fall and level still operate.
- flag[i]:
  - Set by evt[i]; cleared by clr[i] on the next edge.
  - When clr[i] and evt[i] occur in the same cycle, the flag is set (no event is lost).
  - clr on an already-clear flag has no effect.
- irq: combinational OR of the flag registers. It is glitch-free because the flags are registered.
- Input already high at reset release: this is seen as a 0->1 transition and produces a single rise pulse after the normal latency. Software masks it via mode=00 until it is configured.
- Reset mid-operation: all state is discarded immediately, and in-flight filter counts and pulses are lost.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse and flag.

Optional Feature:
- Macro: EDGE_DETECT_MC_EVT_CNT_EN.
- When defined:
  - Adds output evt_cnt, 8*CH bits: an 8-bit saturating counter per channel, bits [8i+7:8i].
  - The counter increments on each evt[i] and holds at 255.
  - clr[i] resets it to 0. If clr[i] and evt[i] occur together, the result is 1.
  - Reset value is 0.
- When undefined: the port and the counters do not exist, and all other behaviour is identical.

Test Plan:
1. filt_len=0, mode[1:0]=01, din[0] 0->1 held: rise[0]=evt[0]=1 for one cycle after edge 2. flag[0]=1 and irq=1 remain until clr[0] is pulsed, then flag[0]=0 and irq=0.
2. filt_len=3: a 3-cycle high glitch on din[1] produces no rise and level[1] stays 0. A 4-cycle high produces rise[1] after edge 2+3=5 with level[1]=1.
3. mode[5:4]=10: toggling din[2] 0->1->0 with 10-cycle spacing gives rise[2] and fall[2] pulses each once, but evt[2] only on the fall. mode=00 gives no evt and no flag.
4. clr[3] pulse in the same cycle as evt[3]: flag[3] stays 1. A further clr[3] with no event gives flag[3]=0.
5. All CH inputs rise in the same cycle with mode=11: all rise, evt and flag bits go high together and irq=1. Asserting rst_n low mid-filter-count clears every output to 0 asynchronously.
6. With EDGE_DETECT_MC_EVT_CNT_EN defined: 300 accepted edges on channel 0 give evt_cnt[7:0]=255. clr[0] gives 0. clr[0] together with evt[0] gives 1.

Source files
------------

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: synchroniser, glitch filter, rise/fall/event pulses, sticky flags, irq.
// Optional per-channel saturating event counters when EDGE_DETECT_MC_EVT_CNT_EN is defined.
module edge_detect_mc #(
    parameter int unsigned CH          = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       din,
    input  logic [2*CH-1:0]     mode,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       rise,
    output logic [CH-1:0]       fall,
    output logic [CH-1:0]       evt,
    output logic [CH-1:0]       flag,
    output logic                irq
`ifdef EDGE_DETECT_MC_EVT_CNT_EN
    ,
    output logic [8*CH-1:0]     evt_cnt
`endif
);

    localparam int unsigned CNT_W = 8;

    logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
    logic [CH-1:0][FILT_W-1:0]      cnt_q, cnt_d;
    logic [CH-1:0]                  level_q, level_d;
    logic [CH-1:0]                  rise_q, rise_d;
    logic [CH-1:0]                  fall_q, fall_d;
    logic [CH-1:0]                  evt_q, evt_d;
    logic [CH-1:0]                  flag_q, flag_d;

    // Synchroniser shift, glitch filter, edge and event decode, sticky flags
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        level_d = level_q;
        cnt_d   = cnt_q;
        evt_d   = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (sync_q[SYNC_STAGES-1][i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= filt_len) begin
                level_d[i] = sync_q[SYNC_STAGES-1][i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + FILT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
        for (int i = 0; i < int'(CH); i++) begin
            evt_d[i] = (rise_d[i] & mode[2*i]) | (fall_d[i] & mode[2*i+1]);
        end
        // A visible event wins over a simultaneous clear so nothing is lost
        flag_d = evt_q | (flag_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            evt_q   <= '0;
            flag_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            evt_q   <= evt_d;
            flag_q  <= flag_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign evt   = evt_q;
    assign flag  = flag_q;
    assign irq   = |flag_q;

`ifdef EDGE_DETECT_MC_EVT_CNT_EN
    logic [CH-1:0][CNT_W-1:0] ecnt_q, ecnt_d;

    // Saturating per-channel event count; clear with a coincident event leaves 1
    always_comb begin
        ecnt_d = ecnt_q;
        for (int i = 0; i < int'(CH); i++) begin
            if (clr[i]) begin
                ecnt_d[i] = CNT_W'(evt_q[i]);
            end else if (evt_q[i] && (ecnt_q[i] != '1)) begin
                ecnt_d[i] = ecnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt_q <= '0;
        end else begin
            ecnt_q <= ecnt_d;
        end
    end

    assign evt_cnt = ecnt_q;
`endif

endmodule
